// File: rtl/wash_scheduler.sv
// Wash-rinse-spin program sequencer feeding the seven-segment display.
// Counts each stage down on a one-second tick; all outputs are registered.
module wash_scheduler #(
  parameter int unsigned WASH_T  = 9,
  parameter int unsigned RINSE_T = 6,
  parameter int unsigned SPIN_T  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       start_pause,
  input  logic       tick,
  output logic [9:0] all,
  output logic [4:0] one,
  output logic [1:0] stage,
  output logic       running,
  output logic       done,
  output logic       power_out
);

  if (WASH_T < 1 || WASH_T > 31 || RINSE_T < 1 || RINSE_T > 31 ||
      SPIN_T < 1 || SPIN_T > 31) begin : g_bad_durations
    $error("wash_scheduler: stage durations must lie in 1..31");
  end

  localparam logic [9:0] TOTAL_T = 10'(WASH_T + RINSE_T + SPIN_T);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] all_q, all_d;
  logic [4:0] one_q, one_d;
  logic [1:0] stage_q, stage_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       power_out_q, power_out_d;

  function automatic logic [4:0] stage_dur(input logic [1:0] s);
    case (s)
      2'd0:    stage_dur = 5'(WASH_T);
      2'd1:    stage_dur = 5'(RINSE_T);
      2'd2:    stage_dur = 5'(SPIN_T);
      default: stage_dur = 5'd0;
    endcase
  endfunction

  // Next-state and counter update; power loss outranks the key, the key outranks the tick.
  always_comb begin
    state_d = state_q;
    all_d   = all_q;
    one_d   = one_q;
    stage_d = stage_q;
    if (!power) begin
      state_d = S_OFF;
      all_d   = 10'd0;
      one_d   = 5'd0;
      stage_d = 2'd0;
    end else begin
      case (state_q)
        S_OFF, S_DONE: begin
          if (state_q == S_OFF || start_pause) begin
            state_d = S_IDLE;
            all_d   = TOTAL_T;
            one_d   = stage_dur(2'd0);
            stage_d = 2'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_IDLE: begin
          if (start_pause) state_d = S_RUN;
          else             state_d = S_IDLE;
        end
        S_RUN: begin
          if (start_pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            if (one_q > 5'd1) begin
              all_d = all_q - 10'd1;
              one_d = one_q - 5'd1;
            end else if (stage_q < 2'd2) begin
              // Load the next stage directly so 'one' never reads zero mid-program.
              all_d   = all_q - 10'd1;
              stage_d = stage_q + 2'd1;
              one_d   = stage_dur(stage_q + 2'd1);
            end else begin
              state_d = S_DONE;
              all_d   = 10'd0;
              one_d   = 5'd0;
            end
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (start_pause) state_d = S_RUN;
          else             state_d = S_PAUSE;
        end
        default: begin
          state_d = S_OFF;
          all_d   = 10'd0;
          one_d   = 5'd0;
          stage_d = 2'd0;
        end
      endcase
    end
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    power_out_d = (state_d != S_OFF);
  end

  // State, counters and status flags registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      all_q       <= 10'd0;
      one_q       <= 5'd0;
      stage_q     <= 2'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      power_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      all_q       <= all_d;
      one_q       <= one_d;
      stage_q     <= stage_d;
      running_q   <= running_d;
      done_q      <= done_d;
      power_out_q <= power_out_d;
    end
  end

  assign all       = all_q;
  assign one       = one_q;
  assign stage     = stage_q;
  assign running   = running_q;
  assign done      = done_q;
  assign power_out = power_out_q;

endmodule

// File: tb/tb_wash_scheduler.sv
// Directed bench for wash_scheduler: an elapsed-seconds reference model feeds a
// scoreboard queue, plus spot checks of the documented display values.
module tb_wash_scheduler;

  localparam int W = 9, R = 6, S = 6, TOT = W + R + S;

  logic       clk = 1'b0;
  logic       rst = 1'b1, power = 1'b1, start_pause = 1'b0, tick = 1'b0;
  logic [9:0] d_all;
  logic [4:0] d_one;
  logic [1:0] d_stage;
  logic       d_running, d_done, d_power_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef enum {M_OFF, M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  mst_t ms = M_OFF;
  int   elapsed = 0;
  logic [19:0] sb_q[$];

  wash_scheduler #(.WASH_T(W), .RINSE_T(R), .SPIN_T(S)) dut (
    .clk(clk), .rst(rst), .power(power), .start_pause(start_pause), .tick(tick),
    .all(d_all), .one(d_one), .stage(d_stage),
    .running(d_running), .done(d_done), .power_out(d_power_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Expected {all, one, stage, running, done, power_out} from the model state.
  function automatic logic [19:0] model_out();
    logic [9:0] a; logic [4:0] o; logic [1:0] s;
    if (elapsed < W)          begin s = 2'd0; o = 5'(W - elapsed); end
    else if (elapsed < W + R) begin s = 2'd1; o = 5'(W + R - elapsed); end
    else                      begin s = 2'd2; o = 5'(TOT - elapsed); end
    a = 10'(TOT - elapsed);
    case (ms)
      M_OFF:   return 20'd0;
      M_DONE:  return {10'd0, 5'd0, 2'd2, 1'b0, 1'b1, 1'b1};
      M_RUN:   return {a, o, s, 1'b1, 1'b0, 1'b1};
      default: return {a, o, s, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic step(input logic r, input logic p, input logic sp, input logic tk);
    logic [19:0] exp_v, obs_v;
    rst = r; power = p; start_pause = sp; tick = tk;
    if (r || !p) ms = M_OFF;
    else begin
      case (ms)
        M_OFF:   begin ms = M_IDLE; elapsed = 0; end
        M_IDLE:  if (sp) ms = M_RUN;
        M_RUN:   if (sp) ms = M_PAUSE;
                 else if (tk) begin
                   elapsed++;
                   if (elapsed == TOT) ms = M_DONE;
                 end
        M_PAUSE: if (sp) ms = M_RUN;
        M_DONE:  if (sp) begin ms = M_IDLE; elapsed = 0; end
        default: ms = M_OFF;
      endcase
    end
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    obs_v = {d_all, d_one, d_stage, d_running, d_done, d_power_out};
    n_assert++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL cycle_outputs: observed %h expected %h (all,one,stage,run,done,pwr)", obs_v, exp_v);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    // Reset for two cycles with power on, then power-up to IDLE.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_power_out", 32'(d_power_out), 32'd0);
    check("reset_all", 32'(d_all), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("idle_all", 32'(d_all), 32'd21);
    check("idle_one", 32'(d_one), 32'd9);
    check("idle_power_out", 32'(d_power_out), 32'd1);

    // Full program.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t9_stage", 32'(d_stage), 32'd1);
    check("t9_one", 32'(d_one), 32'd6);
    check("t9_all", 32'(d_all), 32'd12);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    check("t15_stage", 32'(d_stage), 32'd2);
    check("t15_one", 32'(d_one), 32'd6);
    check("t15_all", 32'(d_all), 32'd6);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t21_done", 32'(d_done), 32'd1);
    check("t21_running", 32'(d_running), 32'd0);
    check("t21_all", 32'(d_all), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Restart from DONE; a tick in the reload cycle and in IDLE does nothing.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("restart_all", 32'(d_all), 32'd21);
    check("restart_done", 32'(d_done), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("idle_tick_all", 32'(d_all), 32'd21);

    // Pause at all=18: five ticks held, then resume and tick once.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("pause_all", 32'(d_all), 32'd18);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("resume_all", 32'(d_all), 32'd17);
    check("resume_one", 32'(d_one), 32'd5);

    // Power loss at all=10, then power back.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("pre_loss_all", 32'(d_all), 32'd10);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("loss_all", 32'(d_all), 32'd0);
    check("loss_power_out", 32'(d_power_out), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("repower_all", 32'(d_all), 32'd21);
    check("repower_one", 32'(d_one), 32'd9);

    // Key/tick collision at all=20, then key held high toggles RUN/PAUSE.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("collision_all", 32'(d_all), 32'd20);
    check("collision_running", 32'(d_running), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-run with power high, then IDLE on the following cycle.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("midrst_power_out", 32'(d_power_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("midrst_idle_all", 32'(d_all), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_scheduler.md
# wash_scheduler

Program sequencer that drives the seven-segment display. It runs a fixed three-stage cycle: wash, then rinse, then spin. It counts each stage down on a one-second tick. It outputs total remaining seconds on `all` (3 display digits) and current-stage remaining seconds on `one` (2 display digits), plus a display-enable `power_out`. All outputs are registered and connect directly to the display block's `all`, `one` and `power` inputs.

## Interface
- `WASH_T`, default 9: wash stage duration in seconds; legal range 1..31.
- `RINSE_T`, default 6: rinse stage duration in seconds; legal range 1..31.
- `SPIN_T`, default 6: spin stage duration in seconds; legal range 1..31. Sum of the three durations is at most 93, so it fits in 10 bits.
- `clk`  in  1: single system clock. Reset is synchronous, active-high (`rst`); all state is sampled on `posedge clk`.
- `rst`  in  1: synchronous active-high reset.
- `power`  in  1: machine power switch, as a level.
- `start_pause`  in  1: one-cycle pulse from the debounced key; meaning depends on state.
- `tick`  in  1: one-cycle pulse, once per second.
- `all`  out  10: total remaining seconds.
- `one`  out  5: remaining seconds of the current stage.
- `stage`  out  2: current stage; 0 = wash, 1 = rinse, 2 = spin; 3 is never driven.
- `running`  out  1: high only in RUN.
- `done`  out  1: high only in DONE.
- `power_out`  out  1: display enable; high in every state except OFF.

## Operation
- States: OFF, IDLE, RUN, PAUSE, DONE.
- Priority each cycle, highest first: `rst`, then `power` low, then `start_pause`, then `tick`.
- `rst`: state OFF; `all`=0, `one`=0, `stage`=0; `running`, `done` and `power_out` all 0.
- `power` low in any state: next state OFF, with outputs set to the reset values.
- OFF with `power` high: next state IDLE. Load `all`=WASH_T+RINSE_T+SPIN_T, `one`=WASH_T, `stage`=0.
- IDLE:
  - `start_pause` moves to RUN.
  - `tick` is ignored.
- RUN:
  - `start_pause` moves to PAUSE. A `tick` in the same cycle is discarded.
  - `tick` with `one`>1: decrement both `all` and `one` by 1.
  - `tick` with `one`==1 and `stage`<2: decrement `all` by 1, increment `stage`, load `one` with the next stage's duration. `one` never shows 0 between stages.
  - `tick` with `one`==1 and `stage`==2: go to DONE with `all`=0 and `one`=0.
- PAUSE:
  - All counters hold and `tick` is ignored.
  - `start_pause` returns to RUN with the counters unchanged.
- DONE:
  - Counters hold at 0.
  - `start_pause` moves to IDLE and reloads the same values as on the OFF→IDLE transition.
- Invariant outside OFF and DONE: `all` equals `one` plus the durations of all stages after `stage`.
- Arithmetic: unsigned. Underflow cannot occur because of the legal parameter ranges and the transition rules above. Out-of-range parameters are unsupported and must be flagged by an elaboration-time check.

## Timing
- Every output changes only on `posedge clk`: one cycle after the input event that causes it. There is no combinational path from input to output.
- `running`, `done` and `power_out` are registered together with the state, so they change in the same cycle as the state.
- Holding `start_pause` high for consecutive cycles toggles RUN↔PAUSE every cycle. De-glitching the key is upstream's responsibility.
- A `tick` in the same cycle as the OFF→IDLE transition or the DONE→IDLE transition has no effect.
- `power` dropping during RUN or PAUSE aborts the program. Power-up always restarts from wash with full durations.
- `rst` in mid-operation behaves the same as a `power` drop, except that the next state is OFF even if `power` is high. IDLE is entered on the following cycle.

## Test plan
- Reset then power up: assert `rst` for 2 cycles with `power`=1 → outputs 0 with `power_out`=0. One cycle after `rst` falls: IDLE, `all`=21, `one`=9, `stage`=0, `power_out`=1.
- Full run: `start_pause`, then 21 ticks. After tick 9: `stage`=1, `one`=6, `all`=12. After tick 15: `stage`=2, `one`=6, `all`=6. After tick 21: `done`=1, `all`=0, `one`=0, `running`=0.
- Pause: in RUN at `all`=18, pulse `start_pause`, apply 5 ticks, pulse `start_pause`, apply 1 tick → `all` holds at 18 throughout PAUSE, then reads 17 with `one`=5.
- Collision: `start_pause` and `tick` in the same cycle while in RUN at `all`=20 → PAUSE, `all` stays 20.
- Power loss: drop `power` in RUN at `all`=10 → next cycle OFF, all outputs 0. Raise `power` → `all`=21, `one`=9, IDLE.
- Restart from DONE: `start_pause` in DONE → IDLE with `all`=21, `one`=9, `done`=0. A tick in IDLE leaves `all`=21.
